sram_responder: RTL
===================

# sram_responder

Memory-side responder for the CPU's instruction and data SRAM ports. Serves the multi-cycle core's fixed-latency, handshake-free interfaces from one shared word array, and returns read data exactly one cycle after the address. After reset, a clear engine zeroes the array. A loader port lets the bench preload programs. Sits between the CPU top and the testbench in the SoC-lite wrapper; replaces the behavioural RAM models.

## Interface
Parameters:
- ADDR_W, 14: word-address width; array depth DEPTH = 2^ADDR_W words of 32 bits.
- BASE_ADDR, 32'h1c00_0000: byte address of word 0; must be aligned to DEPTH*4.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- inst_sram_we  in  1  must be 0; a 1 sets err_inst_we and the write is ignored.
- inst_sram_addr  in  32  instruction byte address; bits [1:0] ignored.
- inst_sram_wdata  in  32  unused.
- inst_sram_rdata  out  32  instruction word, registered.
- data_sram_we  in  1  data write strobe (full word).
- data_sram_addr  in  32  data byte address; bits [1:0] ignored.
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  data word, registered.
- load_valid  in  1  loader write strobe.
- load_addr  in  ADDR_W  loader word index.
- load_data  in  32  loader word.
- init_done  out  1  high once the clear sweep is complete.
- err_range  out  1  sticky; an access fell outside the array.
- err_drop  out  1  sticky; a data write was dropped because of a loader collision.
- err_inst_we  out  1  sticky; inst_sram_we was seen high.
- inst_reads  out  32  count of in-range instruction reads while in RUN.
- data_writes  out  32  count of committed data writes.

## Operation
- FSM states: CLEAR and RUN.
  - reset forces CLEAR with clear pointer 0.
  - CLEAR writes 0 to word[ptr] and increments ptr each cycle. It moves to RUN in the cycle after the write of word DEPTH-1.
  - RUN is held until the next reset.
- Address map: an access is in range iff addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]. The word index is addr[ADDR_W+1:2].
- Reads, RUN only:
  - rdata next cycle = word[index].
  - An out-of-range read returns 32'h0 and sets err_range.
  - Each port is evaluated every cycle; there is no enable.
- Writes, RUN only, one write port:
  - load_valid has priority.
  - If data_sram_we and load_valid are both high in the same cycle, the data write is dropped, err_drop is set, and data_writes is not incremented.
  - An in-range data write with no collision commits and increments data_writes.
  - An out-of-range write is ignored and sets err_range.
- Read/write same word, same cycle: both read ports return the OLD value (read-before-write). The new value is visible from the next address cycle onward.
- During CLEAR:
  - both rdata outputs are 0.
  - data writes and loader writes are ignored; no error flags are set.
  - counters hold at 0.
- Counters wrap at 2^32; no saturation.

## Timing
- Reset values: inst_sram_rdata=0, data_sram_rdata=0, init_done=0, all err_* = 0, inst_reads=0, data_writes=0, state=CLEAR, ptr=0.
- Read latency is 1: an address applied in cycle n gives data in cycle n+1. This matches a CPU that latches the address and samples rdata one state later.
- Write latency is 1: a write in cycle n gives the new data on a read issued in cycle n+1, visible in cycle n+2.
- init_done rises exactly DEPTH cycles after the first cycle with reset low.
- Reset asserted mid-operation, including mid-CLEAR:
  - the next edge returns to CLEAR with ptr=0 and clears flags and counters.
  - the clear sweep restarts from word 0.
- Sticky flags are cleared only by reset.

## Structure
- Shared package sram_resp_pkg holds:
  - the state enum {CLEAR, RUN}
  - the default BASE_ADDR constant
  - the in-range helper function (addr, ADDR_W) -> bit
- One sub-module, responder_ram: DEPTH x 32 storage with one write port, two registered read ports, and read-before-write semantics.
- The top level holds the FSM, write-port mux (clear > loader > data), address decode, flags and counters.

## Test plan
- Clear sweep, ADDR_W=4: release reset.
  - init_done rises after exactly 16 cycles.
  - reads of 0x1c00_0000..0x1c00_003c return 0.
  - a loader write during CLEAR is absent after the sweep.
- Loader then fetch:
  - load word 0 = 32'h0280_0421, then present inst_sram_addr=0x1c00_0000 → that word appears next cycle.
  - inst_reads = 1.
- Data write/read-before-write: write 32'hdead_beef to 0x1c00_0010 with data_sram_addr held.
  - the same-cycle read returns the old value.
  - the next cycle's read returns dead_beef.
  - data_writes = 1.
- Collision: load_valid and data_sram_we in the same cycle on different words.
  - only the loader word changes.
  - err_drop = 1.
  - data_writes is unchanged.
- Range error: read and write 0x1bff_fffc.
  - rdata = 0; memory is unchanged.
  - err_range = 1.
- Reset mid-CLEAR at cycle 5: reassert reset for one cycle.
  - init_done rises 16 cycles after the release.
  - flags and counters read 0.

Source files
------------

// File: rtl/sram_resp_pkg.sv
// sram_resp_pkg: shared state type, default base address and address-range helper for sram_responder
package sram_resp_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1c00_0000;
  // true when addr falls inside the 2^addr_w-word window starting at base
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base, input int addr_w);
    return (addr >> (addr_w + 2)) == (base >> (addr_w + 2));
  endfunction
endpackage

// File: rtl/responder_ram.sv
// responder_ram: 2^ADDR_W x 32 storage, one write port, two registered read ports, read-before-write
// ports: clk/reset; we/waddr/wdata write port; re_a/raddr_a/rdata_a and re_b/raddr_b/rdata_b read ports
//        (a disabled or reset read port returns 0 on the next cycle)
module responder_ram
  import sram_resp_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [31:0]       rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [31:0]       rdata_b
);
  logic [31:0] mem [2**ADDR_W];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  // non-blocking reads sample the pre-write contents, giving read-before-write
  always_ff @(posedge clk) begin
    rdata_a <= (reset || !re_a) ? '0 : mem[raddr_a];
    rdata_b <= (reset || !re_b) ? '0 : mem[raddr_b];
  end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: shared-array responder for CPU instruction/data SRAM ports with clear sweep and loader
// ports: clk, reset (sync, active-high); inst_sram_* instruction port (read-only); data_sram_* data port;
//        load_* loader write port; init_done after the clear sweep; sticky err_range/err_drop/err_inst_we;
//        inst_reads and data_writes wrapping counters
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_sram_we,
  input  logic [31:0]       inst_sram_addr,
  input  logic [31:0]       inst_sram_wdata,
  output logic [31:0]       inst_sram_rdata,
  input  logic              data_sram_we,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              init_done,
  output logic              err_range,
  output logic              err_drop,
  output logic              err_inst_we,
  output logic [31:0]       inst_reads,
  output logic [31:0]       data_writes
);
  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              run, inst_ok, data_ok, data_commit, we;
  logic [ADDR_W-1:0] inst_idx, data_idx, waddr;
  logic [31:0]       wdata;
  logic              unused;
  assign unused      = ^{inst_sram_wdata, inst_sram_addr[1:0], data_sram_addr[1:0]};
  assign run         = state == RUN;
  assign inst_ok     = in_range(inst_sram_addr, BASE_ADDR, ADDR_W);
  assign data_ok     = in_range(data_sram_addr, BASE_ADDR, ADDR_W);
  assign inst_idx    = inst_sram_addr[ADDR_W+1:2];
  assign data_idx    = data_sram_addr[ADDR_W+1:2];
  assign data_commit = run && data_sram_we && data_ok && !load_valid;
  // single write port: clear sweep > loader > data
  assign we    = !reset && (!run || load_valid || data_commit);
  assign waddr = !run ? ptr : load_valid ? load_addr : data_idx;
  assign wdata = !run ? '0 : load_valid ? load_data : data_sram_wdata;
  responder_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re_a    (run && inst_ok),
    .raddr_a (inst_idx),
    .rdata_a (inst_sram_rdata),
    .re_b    (run && data_ok),
    .raddr_b (data_idx),
    .rdata_b (data_sram_rdata)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR;
      ptr         <= '0;
      init_done   <= 1'b0;
      err_range   <= 1'b0;
      err_drop    <= 1'b0;
      err_inst_we <= 1'b0;
      inst_reads  <= '0;
      data_writes <= '0;
    end else if (!run) begin
      ptr <= ptr + 1'b1;
      if (&ptr) begin
        state     <= RUN;
        init_done <= 1'b1;
      end
    end else begin
      if (!inst_ok || !data_ok) err_range <= 1'b1;
      if (load_valid && data_sram_we) err_drop <= 1'b1;
      if (inst_sram_we) err_inst_we <= 1'b1;
      if (inst_ok) inst_reads <= inst_reads + 32'd1;
      if (data_commit) data_writes <= data_writes + 32'd1;
    end
  end
endmodule
